// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file.
//   clr_state_e : scrub controller states (CLEAR owns the array, READY serves writes)
//   ZERO_IDX    : architectural index that is hardwired to zero
//   idx_width() : index width for a given register count
package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_e;

   localparam int ZERO_IDX = 0;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Scrub controller: after reset or a clear request it walks clr_idx from 1 to
// NREGS-1, zeroing one entry per cycle, then hands the array back.
//   clk, rst   : clock, synchronous active-high reset
//   clear_req  : request a full scrub (honoured only in READY)
//   busy       : scrub owns the array (also high while rst is asserted)
//   clr_en     : zero the entry at clr_idx on this edge
//   clr_idx    : entry being scrubbed
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter  int NREGS = 32,
   localparam int AW    = idx_width(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_req,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_idx
);

   localparam logic [AW-1:0] ONE_IDX   = AW'(1);
   localparam logic [AW-1:0] FIRST_IDX = AW'(ZERO_IDX + 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

   clr_state_e    r_state;
   clr_state_e    w_state_nxt;
   logic [AW-1:0] r_clr_idx;
   logic [AW-1:0] w_clr_idx_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= CLEAR;
         r_clr_idx <= FIRST_IDX;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_idx <= w_clr_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      busy          = 1'b1;
      clr_en        = 1'b0;
      case (r_state)
         CLEAR: begin
            // clear_req is deliberately ignored here: a running scrub never restarts
            clr_en        = 1'b1;
            w_clr_idx_nxt = r_clr_idx + ONE_IDX;
            if (r_clr_idx == LAST_IDX) begin
               w_state_nxt = READY;
            end
         end
         READY: begin
            busy = 1'b0;
            if (clear_req) begin
               w_state_nxt   = CLEAR;
               w_clr_idx_nxt = FIRST_IDX;
            end
         end
         default: begin
            w_state_nxt   = CLEAR;
            w_clr_idx_nxt = FIRST_IDX;
         end
      endcase
      // rst is visible combinationally so busy is high from the very first reset cycle
      if (rst) begin
         busy   = 1'b1;
         clr_en = 1'b0;
      end
   end

   assign clr_idx = r_clr_idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised integer register file: NREAD combinational read ports, one write
// port, optional write-to-read bypass, and a scrub engine that zeroes the array.
//   clk, rst    : clock, synchronous active-high reset (starts a scrub)
//   reg_write   : write enable; rd / write_data : destination and data
//   rs          : packed read indices, port i = rs[i*AW +: AW]
//   read_data   : packed read data,    port i = read_data[i*XLEN +: XLEN]
//   clear_req   : request a full scrub; busy : scrub in progress, stall issue
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int XLEN   = 64,
   parameter  int NREGS  = 32,
   parameter  int NREAD  = 2,
   parameter  int BYPASS = 1,
   localparam int AW     = idx_width(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_write,
   input  logic [AW-1:0]         rd,
   input  logic [XLEN-1:0]       write_data,
   input  logic [NREAD*AW-1:0]   rs,
   output logic [NREAD*XLEN-1:0] read_data,
   input  logic                  clear_req,
   output logic                  busy
);

   localparam logic [AW-1:0] W_ZERO = AW'(ZERO_IDX);

   logic            w_clr_en;
   logic [AW-1:0]   w_clr_idx;
   logic            w_wr_en;
   // index 0 is never stored
   logic [XLEN-1:0] r_regs [1:NREGS-1];

   regfile_clear_fsm #(
      .NREGS (NREGS)
   ) u_clear_fsm (
      .clk       (clk),
      .rst       (rst),
      .clear_req (clear_req),
      .busy      (busy),
      .clr_en    (w_clr_en),
      .clr_idx   (w_clr_idx)
   );

   // A clear request wins over a write issued in the same cycle
   assign w_wr_en = reg_write && !busy && !clear_req && (rd != W_ZERO);

   always_ff @(posedge clk) begin
      if (w_clr_en) begin
         if (w_clr_idx != W_ZERO) begin
            r_regs[w_clr_idx] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[rd] <= write_data;
      end
   end

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0]   w_rs;
      logic [XLEN-1:0] w_data;

      assign w_rs = rs[g*AW +: AW];

      always_comb begin
         w_data = '0;
         if (busy || (w_rs == W_ZERO)) begin
            w_data = '0;
         end else if ((BYPASS != 0) && reg_write && (rd == w_rs)) begin
            w_data = write_data;
         end else begin
            w_data = r_regs[w_rs];
         end
      end

      assign read_data[g*XLEN +: XLEN] = w_data;
   end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // group AB: two 64x32x2 instances sharing inputs, bypass on (A) / off (B)
   logic         rst_a, we_a, clr_a;
   logic [4:0]   rd_a;
   logic [63:0]  wd_a;
   logic [9:0]   rs_a;
   logic [127:0] rdat_a, rdat_b;
   logic         busy_a, busy_b;
   // group C: 32x16x3 instance
   logic         rst_c, we_c, clr_c;
   logic [3:0]   rd_c;
   logic [31:0]  wd_c;
   logic [11:0]  rs_c;
   logic [95:0]  rdat_c;
   logic         busy_c;

   regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst_a), .reg_write(we_a), .rd(rd_a), .write_data(wd_a),
      .rs(rs_a), .read_data(rdat_a), .clear_req(clr_a), .busy(busy_a));

   regfile_mp #(.XLEN(64), .NREGS(32), .NREAD(2), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst_a), .reg_write(we_a), .rd(rd_a), .write_data(wd_a),
      .rs(rs_a), .read_data(rdat_b), .clear_req(clr_a), .busy(busy_b));

   regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(3), .BYPASS(1)) dut_c (
      .clk(clk), .rst(rst_c), .reg_write(we_c), .rd(rd_c), .write_data(wd_c),
      .rs(rs_c), .read_data(rdat_c), .clear_req(clr_c), .busy(busy_c));

   int errors = 0;
   int checks = 0;

   // Reference model: contents plus "edges of scrub remaining". Starting a scrub
   // zeroes the model at once; the difference is invisible since reads give 0
   // and writes are dropped until the countdown expires.
   logic [63:0] m_ab [32];
   int          left_ab = 0;
   logic [31:0] m_c [16];
   int          left_c = 0;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [63:0] wd;
      logic [4:0]  s0, s1;
      logic [63:0] ea0, ea1, eb0, eb1;
   } vec_t;
   vec_t vecs[8];

   function automatic logic [63:0] exp_ab(input int p, input bit byp);
      logic [4:0] s;
      s = rs_a[p*5 +: 5];
      if (rst_a || left_ab > 0) return 64'd0;
      if (s == 5'd0) return 64'd0;
      if (byp && we_a && rd_a == s) return wd_a;
      return m_ab[s];
   endfunction

   function automatic logic [31:0] exp_c(input int p);
      logic [3:0] s;
      s = rs_c[p*4 +: 4];
      if (rst_c || left_c > 0) return 32'd0;
      if (s == 4'd0) return 32'd0;
      if (we_c && rd_c == s) return wd_c;
      return m_c[s];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Check all outputs at the falling edge, then advance the model at the rising edge.
   task automatic step();
      @(negedge clk);
      chk("busy_a", 64'(busy_a), 64'(rst_a || left_ab > 0));
      chk("busy_b", 64'(busy_b), 64'(rst_a || left_ab > 0));
      chk("busy_c", 64'(busy_c), 64'(rst_c || left_c > 0));
      for (int p = 0; p < 2; p++) begin
         chk("model_a", rdat_a[p*64 +: 64], exp_ab(p, 1'b1));
         chk("model_b", rdat_b[p*64 +: 64], exp_ab(p, 1'b0));
      end
      for (int p = 0; p < 3; p++) begin
         chk("model_c", 64'(rdat_c[p*32 +: 32]), 64'(exp_c(p)));
      end
      @(posedge clk);
      if (rst_a) begin
         left_ab = 31;
         for (int i = 0; i < 32; i++) m_ab[i] = 64'd0;
      end else if (left_ab > 0) begin
         left_ab--;
      end else if (clr_a) begin
         left_ab = 31;
         for (int i = 0; i < 32; i++) m_ab[i] = 64'd0;
      end else if (we_a && rd_a != 5'd0) begin
         m_ab[rd_a] = wd_a;
      end
      if (rst_c) begin
         left_c = 15;
         for (int i = 0; i < 16; i++) m_c[i] = 32'd0;
      end else if (left_c > 0) begin
         left_c--;
      end else if (clr_c) begin
         left_c = 15;
         for (int i = 0; i < 16; i++) m_c[i] = 32'd0;
      end else if (we_c && rd_c != 4'd0) begin
         m_c[rd_c] = wd_c;
      end
      #1;
   endtask

   // Count cycles with busy high over a bounded window, optionally attempting
   // writes on A while its scrub runs and pulsing clear_req on C during CLEAR.
   task automatic window(input int len, input bit noise_a, input bit noise_c,
                         output int na, output int nc);
      na = 0;
      nc = 0;
      for (int k = 0; k < len; k++) begin
         if (busy_a) na++;
         if (busy_c) nc++;
         if (noise_a) begin
            we_a = (left_ab > 0);
            rd_a = 5'($urandom);
            wd_a = {$urandom, $urandom};
         end
         if (noise_c) clr_c = (left_c > 0) ? 1'($urandom) : 1'b0;
         step();
      end
      we_a  = 1'b0;
      clr_c = 1'b0;
   endtask

   task automatic read_all_zero_a();
      for (int i = 0; i < 32; i++) begin
         rs_a = {5'(i), 5'(i)};
         #1;
         chk("zero_a0", rdat_a[63:0], 64'd0);
         chk("zero_a1", rdat_a[127:64], 64'd0);
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int na, nc;
      logic [31:0] v2, v9, v15;

      rst_a = 1'b1; we_a = 1'b0; clr_a = 1'b0; rd_a = '0; wd_a = '0; rs_a = 10'h3FF;
      rst_c = 1'b1; we_c = 1'b0; clr_c = 1'b0; rd_c = '0; wd_c = '0; rs_c = 12'hFFF;
      for (int i = 0; i < 32; i++) m_ab[i] = 64'd0;
      for (int i = 0; i < 16; i++) m_c[i] = 32'd0;

      // reset held for two cycles: busy high, reads zero
      step();
      step();
      rst_a = 1'b0;
      rst_c = 1'b0;
      window(45, 1'b0, 1'b0, na, nc);
      chk("reset_scrub_len_a", 64'(na), 64'd31);
      chk("reset_scrub_len_c", 64'(nc), 64'd15);
      read_all_zero_a();

      // directed write/read/bypass vectors, starting from an all-zero file
      vecs[0] = '{1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd0,
                  64'hDEAD_BEEF_0000_0001, 64'd0, 64'd0, 64'd0};
      vecs[1] = '{1'b0, 5'd0, 64'd0, 5'd5, 5'd5,
                  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,
                  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
      vecs[2] = '{1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd5,
                  64'd0, 64'hDEAD_BEEF_0000_0001, 64'd0, 64'hDEAD_BEEF_0000_0001};
      vecs[3] = '{1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0};
      vecs[4] = '{1'b1, 5'd7, 64'h1234, 5'd7, 5'd7, 64'h1234, 64'h1234, 64'd0, 64'd0};
      vecs[5] = '{1'b0, 5'd0, 64'd0, 5'd7, 5'd7, 64'h1234, 64'h1234, 64'h1234, 64'h1234};
      vecs[6] = '{1'b1, 5'd5, 64'h55, 5'd5, 5'd7,
                  64'h55, 64'h1234, 64'hDEAD_BEEF_0000_0001, 64'h1234};
      vecs[7] = '{1'b0, 5'd0, 64'd0, 5'd5, 5'd5, 64'h55, 64'h55, 64'h55, 64'h55};
      for (int v = 0; v < 8; v++) begin
         we_a = vecs[v].we;
         rd_a = vecs[v].rd;
         wd_a = vecs[v].wd;
         rs_a = {vecs[v].s1, vecs[v].s0};
         #1;
         chk("vec_a0", rdat_a[63:0],   vecs[v].ea0);
         chk("vec_a1", rdat_a[127:64], vecs[v].ea1);
         chk("vec_b0", rdat_b[63:0],   vecs[v].eb0);
         chk("vec_b1", rdat_b[127:64], vecs[v].eb1);
         step();
      end
      we_a = 1'b0;

      // fill x1..x31 with their index, then clear_req colliding with a write to x3
      for (int i = 1; i < 32; i++) begin
         we_a = 1'b1; rd_a = 5'(i); wd_a = 64'(i); rs_a = {5'(i), 5'(i - 1)};
         step();
      end
      rs_a = {5'd4, 5'd3};
      we_a = 1'b0;
      #1;
      chk("fill_x3", rdat_a[63:0], 64'd3);
      chk("fill_x4", rdat_a[127:64], 64'd4);
      clr_a = 1'b1; we_a = 1'b1; rd_a = 5'd3; wd_a = 64'hAA;
      step();
      clr_a = 1'b0; we_a = 1'b0;
      window(40, 1'b0, 1'b0, na, nc);
      chk("clear_scrub_len", 64'(na), 64'd31);
      rs_a = {5'd31, 5'd3};
      #1;
      chk("clear_x3_dropped", rdat_a[63:0], 64'd0);
      chk("clear_x31", rdat_a[127:64], 64'd0);
      step();

      // refill a few, then reset 10 cycles into a scrub with writes attempted throughout
      for (int i = 1; i < 6; i++) begin
         we_a = 1'b1; rd_a = 5'(i); wd_a = 64'hC0DE_0000 + 64'(i);
         step();
      end
      we_a = 1'b0;
      clr_a = 1'b1;
      step();
      clr_a = 1'b0;
      repeat (10) begin
         we_a = 1'b1; rd_a = 5'($urandom); wd_a = {$urandom, $urandom};
         step();
      end
      we_a = 1'b0;
      rst_a = 1'b1;
      step();
      rst_a = 1'b0;
      window(40, 1'b1, 1'b0, na, nc);
      chk("rst_mid_scrub_len", 64'(na), 64'd31);
      read_all_zero_a();

      // 16-entry instance: three simultaneous reads, then clear_req spam during CLEAR
      v2 = $urandom; v9 = $urandom; v15 = $urandom;
      we_c = 1'b1; rd_c = 4'd2;  wd_c = v2;  step();
      rd_c = 4'd9;  wd_c = v9;  step();
      rd_c = 4'd15; wd_c = v15; step();
      we_c = 1'b0;
      rs_c = {4'd15, 4'd9, 4'd2};
      #1;
      chk("c_read_x2",  64'(rdat_c[31:0]),  64'(v2));
      chk("c_read_x9",  64'(rdat_c[63:32]), 64'(v9));
      chk("c_read_x15", 64'(rdat_c[95:64]), 64'(v15));
      step();
      clr_c = 1'b1;
      step();
      clr_c = 1'b0;
      window(30, 1'b0, 1'b1, na, nc);
      chk("c_clear_len", 64'(nc), 64'd15);

      // randomized traffic on both groups against the model
      for (int k = 0; k < 700; k++) begin
         rst_a = ($urandom_range(0, 299) == 0);
         clr_a = ($urandom_range(0, 79) == 0);
         we_a  = 1'($urandom);
         rd_a  = 5'($urandom);
         wd_a  = {$urandom, $urandom};
         rs_a  = 10'($urandom);
         rst_c = ($urandom_range(0, 299) == 0);
         clr_c = ($urandom_range(0, 59) == 0);
         we_c  = 1'($urandom);
         rd_c  = 4'($urandom);
         wd_c  = $urandom;
         rs_c  = 12'($urandom);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
